// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default line constants
// and the data-width/parity helper used by uart_rx_top.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50000000;
  localparam int BAUD_DEF     = 9600;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Even-parity bit for a data byte: the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_bps_gen.sv
// Receive baud generator: counts 0..BPS_CNT-1 while bps_start is high and
// flags clk_bps at mid-bit (count == BPS_HALF); held at zero otherwise.
module uart_rx_bps_gen #(
  parameter int BPS_CNT  = 5208,
  parameter int BPS_HALF = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bps_start,
  output logic clk_bps
);

  localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter, cleared whenever the receiver is not framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!bps_start) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_W'(BPS_CNT - 1)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign clk_bps = (cnt_r == CNT_W'(BPS_HALF));

endmodule

// File: rtl/uart_rx_top.sv
// RS232 receive top: synchroniser, start-edge detect, mid-bit sampling FSM.
// Define UART_RX_PARITY_EN for 8E1 frames with rx_parity_err; default is 8N1.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int BPS_CNT  = CLK_FREQ / BAUD,
  parameter int BPS_HALF = BPS_CNT / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_int,
  output logic              rx_end,
  output logic              rx_frame_err,
  output logic              rx_parity_err
);

  logic              sync_q1_r, sync_q2_r, sync_q3_r;
  logic              start_edge_s;
  logic              clk_bps_s;
  rx_state_e         state_r, state_s;
  logic [2:0]        bit_idx_r, bit_idx_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [DATA_W-1:0] rx_data_r, rx_data_s;
  logic              bps_start_r, bps_start_s;
  logic              rx_int_r, rx_int_s;
  logic              rx_end_r, rx_end_s;
  logic              frame_err_r, frame_err_s;
`ifdef UART_RX_PARITY_EN
  logic              par_ok_r, par_ok_s;
  logic              parity_err_r, parity_err_s;
`endif

  // Two-flop synchroniser plus a third stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1_r <= 1'b1;
      sync_q2_r <= 1'b1;
      sync_q3_r <= 1'b1;
    end else begin
      sync_q1_r <= rs232_rx;
      sync_q2_r <= sync_q1_r;
      sync_q3_r <= sync_q2_r;
    end
  end

  assign start_edge_s = !sync_q2_r && sync_q3_r;

  uart_rx_bps_gen #(
    .BPS_CNT  (BPS_CNT),
    .BPS_HALF (BPS_HALF)
  ) u_bps_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .bps_start (bps_start_r),
    .clk_bps   (clk_bps_s)
  );

  // Frame FSM: next state, shift register and strobe generation.
  always_comb begin
    state_s     = state_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    rx_data_s   = rx_data_r;
    bps_start_s = bps_start_r;
    rx_int_s    = rx_int_r;
    rx_end_s    = 1'b0;
    frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_s     = par_ok_r;
    parity_err_s = 1'b0;
`endif
    case (state_r)
      RX_IDLE: begin
        if (start_edge_s) begin
          bps_start_s = 1'b1;
          rx_int_s    = 1'b1;
          state_s     = RX_START;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (!clk_bps_s) begin
          state_s = RX_START;
        end else if (sync_q2_r) begin
          // Line back high at mid start bit: a glitch, abandon silently.
          bps_start_s = 1'b0;
          rx_int_s    = 1'b0;
          state_s     = RX_IDLE;
        end else begin
          bit_idx_s = 3'd0;
          state_s   = RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_bps_s) begin
          shift_s[bit_idx_r] = sync_q2_r;
          bit_idx_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_s = RX_PARITY;
`else
            state_s = RX_STOP;
`endif
          end else begin
            state_s = RX_DATA;
          end
        end else begin
          state_s = RX_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (clk_bps_s) begin
          par_ok_s = (sync_q2_r == even_parity(shift_r));
          state_s  = RX_STOP;
        end else begin
          state_s = RX_PARITY;
        end
      end
`endif
      RX_STOP: begin
        if (clk_bps_s) begin
          bps_start_s = 1'b0;
          rx_int_s    = 1'b0;
          state_s     = RX_IDLE;
          if (!sync_q2_r) begin
            frame_err_s = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!par_ok_r) begin
            parity_err_s = 1'b1;
`endif
          end else begin
            rx_data_s = shift_r;
            rx_end_s  = 1'b1;
          end
        end else begin
          state_s = RX_STOP;
        end
      end
      default: begin
        bps_start_s = 1'b0;
        rx_int_s    = 1'b0;
        state_s     = RX_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RX_IDLE;
      bit_idx_r    <= 3'd0;
      shift_r      <= {DATA_W{1'b0}};
      rx_data_r    <= {DATA_W{1'b0}};
      bps_start_r  <= 1'b0;
      rx_int_r     <= 1'b0;
      rx_end_r     <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_r     <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      bit_idx_r    <= bit_idx_s;
      shift_r      <= shift_s;
      rx_data_r    <= rx_data_s;
      bps_start_r  <= bps_start_s;
      rx_int_r     <= rx_int_s;
      rx_end_r     <= rx_end_s;
      frame_err_r  <= frame_err_s;
`ifdef UART_RX_PARITY_EN
      par_ok_r     <= par_ok_s;
      parity_err_r <= parity_err_s;
`endif
    end
  end

  assign rx_data      = rx_data_r;
  assign rx_int       = rx_int_r;
  assign rx_end       = rx_end_r;
  assign rx_frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_r;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top at a short bit period (16 clk/bit);
// frames are generated bit by bit and outcomes predicted from frame rules.
module tb_uart_rx_top;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 3125000;
  localparam int BPS      = CLK_FREQ / BAUD;
  localparam int HALF     = BPS / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int, rx_end, rx_frame_err, rx_parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drive_cyc = 0;
  logic [7:0] exp_data = 8'h00;

  // Event records gathered by the monitor.
  int end_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap_cnt = 0;
  int end_cyc = 0, strobe_cyc = 0, rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] end_data = 8'h00;
  logic prev_int = 1'b0;

  uart_rx_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs232_rx      (rs232_rx),
    .rx_data       (rx_data),
    .rx_int        (rx_int),
    .rx_end        (rx_end),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_int <= rx_int;
    if (rx_int && !prev_int) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!rx_int && prev_int) fall_cyc <= cyc;
    if (rx_end) begin
      end_cnt  <= end_cnt + 1;
      end_cyc  <= cyc;
      end_data <= rx_data;
    end
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_parity_err) perr_cnt <= perr_cnt + 1;
    if (rx_end || rx_frame_err || rx_parity_err) strobe_cyc <= cyc;
    if ((int'(rx_end) + int'(rx_frame_err) + int'(rx_parity_err)) > 1)
      overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rs232_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_cyc = cyc;
    drive_bit(1'b0, BPS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BPS);
    if (PAR_EN) drive_bit((^d) ^ par_flip, BPS);
    drive_bit(stop_b, BPS);
    if (!stop_b) drive_bit(1'b1, BPS);
  endtask

  task automatic frame_test(input string tag, input logic [7:0] d, input logic stop_b,
                            input logic par_flip);
    int e0, f0, p0, r0, lat, exp_lat;
    logic exp_f, exp_p, exp_end;
    e0 = end_cnt; f0 = ferr_cnt; p0 = perr_cnt; r0 = rise_cnt;
    exp_f   = !stop_b;
    exp_p   = stop_b && PAR_EN && par_flip;
    exp_end = !exp_f && !exp_p;
    send_frame(d, stop_b, par_flip);
    chk({tag, "_end"}, end_cnt - e0, {31'd0, exp_end});
    chk({tag, "_ferr"}, ferr_cnt - f0, {31'd0, exp_f});
    chk({tag, "_perr"}, perr_cnt - p0, {31'd0, exp_p});
    chk({tag, "_int_rise"}, rise_cnt - r0, 1);
    chk({tag, "_int_fall"}, fall_cyc, strobe_cyc);
    if (exp_end) begin
      exp_data = d;
      chk({tag, "_end_data"}, end_data, d);
      exp_lat = 3 + 9 * BPS + HALF + (PAR_EN ? BPS : 0);
      lat = end_cyc - drive_cyc - 1;
      chk({tag, "_latency"}, (lat >= exp_lat - 1 && lat <= exp_lat + 1) ? exp_lat : lat, exp_lat);
    end
    chk({tag, "_rx_data"}, rx_data, exp_data);
    chk({tag, "_int_idle"}, rx_int, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_int"}, rx_int, 1'b0);
    chk({tag, "_end"}, rx_end, 1'b0);
    chk({tag, "_ferr"}, rx_frame_err, 1'b0);
    chk({tag, "_perr"}, rx_parity_err, 1'b0);
  endtask

  initial begin
    int e0, f0, p0, r0;
    logic [7:0] rb;
    logic rs, rp;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    frame_test("a5", 8'hA5, 1'b1, 1'b0);
    frame_test("b2b_00", 8'h00, 1'b1, 1'b0);
    frame_test("b2b_ff", 8'hFF, 1'b1, 1'b0);

    // Short low glitch on an idle line: false start, no strobes.
    e0 = end_cnt; f0 = ferr_cnt; p0 = perr_cnt; r0 = rise_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * BPS);
    chk("glitch_strobes", (end_cnt - e0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
    chk("glitch_int_rise", rise_cnt - r0, 1);
    chk("glitch_int_width", (fall_cyc > rise_cyc && fall_cyc - rise_cyc <= HALF + 4) ? 1 : 0, 1);
    frame_test("3c", 8'h3C, 1'b1, 1'b0);

    frame_test("55_badstop", 8'h55, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_test($sformatf("rnd%0d", i), rb, rs, rp);
    end

    // Break: line held low well past a frame, then released.
    e0 = end_cnt; f0 = ferr_cnt; r0 = rise_cnt;
    drive_bit(1'b0, 25 * BPS);
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_end", end_cnt - e0, 0);
    chk("break_int", rx_int, 1'b0);
    drive_bit(1'b1, 2 * BPS);
    chk("break_no_retrigger", rise_cnt - r0, 1);

    // Reset in the middle of the data bits of 8'h81.
    e0 = end_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, BPS);
    drive_bit(1'b1, BPS);
    drive_bit(1'b0, HALF);
    chk("midrst_busy", rx_int, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_data = 8'h00;
    rs232_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_strobe", (end_cnt - e0) + (ferr_cnt - f0), 0);
    frame_test("81_after_rst", 8'h81, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    frame_test("07_badpar", 8'h07, 1'b1, 1'b1);
    frame_test("07_goodpar", 8'h07, 1'b1, 1'b0);
`endif

    chk("strobe_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
